// File: rtl/idu_pkg.sv
// Shared constants for the increment/decrement unit.
package idu_pkg;

  localparam int unsigned IDU_WIDTH = 16;
  localparam logic        IDU_DEC   = 1'b0;
  localparam logic        IDU_INC   = 1'b1;

endpackage : idu_pkg

// File: rtl/idu_core.sv
// Combinational +/-1 datapath: next value plus wrap (carry/borrow out) and zero flags.
module idu_core
  import idu_pkg::*;
#(
  parameter int unsigned WIDTH = IDU_WIDTH
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic             mode,
  output logic [WIDTH-1:0] next_value,
  output logic             next_wrap,
  output logic             next_zero
);

  localparam int unsigned EXT_W = WIDTH + 1;

  logic [EXT_W-1:0] ext_operand;
  logic [EXT_W-1:0] ext_result;

  // One extra bit catches the carry on increment and the borrow on decrement.
  always_comb begin
    ext_operand = EXT_W'({1'b0, data_in});
    ext_result  = (mode == IDU_INC) ? ext_operand + EXT_W'(1)
                                    : ext_operand - EXT_W'(1);
    next_value  = ext_result[WIDTH-1:0];
    next_wrap   = ext_result[WIDTH];
    next_zero   = (ext_result[WIDTH-1:0] == '0);
  end

endmodule : idu_core

// File: rtl/idu.sv
// Increment/decrement unit: output registers with synchronous reset around idu_core.
module idu
  import idu_pkg::*;
#(
  parameter int unsigned WIDTH = IDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             mode,
  output logic [WIDTH-1:0] data_out,
  output logic             wrap,
  output logic             zero
);

  logic [WIDTH-1:0] core_value;
  logic             core_wrap;
  logic             core_zero;

  logic [WIDTH-1:0] data_d, data_q;
  logic             wrap_d, wrap_q;
  logic             zero_d, zero_q;

  idu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .data_in    (data_in),
    .mode       (mode),
    .next_value (core_value),
    .next_wrap  (core_wrap),
    .next_zero  (core_zero)
  );

  always_comb begin
    data_d = core_value;
    wrap_d = core_wrap;
    zero_d = core_zero;
  end

  // Reset state reports a zero result with no wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      wrap_q <= 1'b0;
      zero_q <= 1'b1;
    end else begin
      data_q <= data_d;
      wrap_q <= wrap_d;
      zero_q <= zero_d;
    end
  end

  assign data_out = data_q;
  assign wrap     = wrap_q;
  assign zero     = zero_q;

endmodule : idu

// File: tb/tb_idu.sv
// Randomized scoreboard bench for idu against an integer-arithmetic reference model.
module tb_idu;

  localparam int unsigned W       = 16;
  localparam longint      MODULUS = 64'sd65536;

  typedef struct {
    logic [W-1:0] data;
    logic         wrap;
    logic         zero;
    string        name;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] data_in = '0;
  logic         mode = 1'b1;
  logic [W-1:0] data_out;
  logic         wrap;
  logic         zero;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  idu #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .mode     (mode),
    .data_out (data_out),
    .wrap     (wrap),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  // Reference: integer +/-1, wrap when the result falls outside [0, 2^W).
  function automatic exp_t model(input logic r, input logic [W-1:0] d, input logic m,
                                 input string name);
    exp_t   e;
    longint v;
    e.name = name;
    if (r) begin
      e.data = '0;
      e.wrap = 1'b0;
      e.zero = 1'b1;
    end else begin
      v = longint'(d) + (m ? 64'sd1 : -64'sd1);
      e.wrap = (v < 0) || (v >= MODULUS);
      if (v < 0) v = v + MODULUS;
      if (v >= MODULUS) v = v - MODULUS;
      e.data = W'(v);
      e.zero = (v == 0);
    end
    return e;
  endfunction

  // Apply one cycle of stimulus away from the active edge and log its expected result.
  task automatic drive(input logic r, input logic [W-1:0] d, input logic m, input string name);
    @(negedge clk);
    rst     = r;
    data_in = d;
    mode    = m;
    exp_q.push_back(model(r, d, m, name));
  endtask

  // Monitor: the DUT presents a result after every rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (data_out !== e.data || wrap !== e.wrap || zero !== e.zero) begin
        n_fails++;
        $display("FAIL %s: got data_out=%h wrap=%b zero=%b, expected data_out=%h wrap=%b zero=%b",
                 e.name, data_out, wrap, zero, e.data, e.wrap, e.zero);
      end
    end
  end

  initial begin
    logic [W-1:0] d;
    logic         m;
    logic         r;
    int           sel;

    drive(1'b1, 16'h0000, 1'b1, "reset");
    drive(1'b0, 16'd17,   1'b1, "inc_17");
    drive(1'b0, 16'd17,   1'b0, "dec_17");
    drive(1'b0, 16'hFFFF, 1'b1, "inc_wrap");
    drive(1'b0, 16'h0000, 1'b0, "dec_wrap");
    drive(1'b0, 16'h0001, 1'b0, "dec_to_zero");
    drive(1'b0, 16'hFFFE, 1'b1, "inc_to_max");
    drive(1'b0, 16'h1234, 1'b1, "stream_a");
    drive(1'b0, 16'h1234, 1'b1, "stream_b");
    drive(1'b1, 16'h1234, 1'b1, "reset_mid");
    drive(1'b0, 16'h1234, 1'b1, "after_reset");
    drive(1'b1, 16'h0000, 1'b0, "reset_over_dec_wrap");
    drive(1'b0, 16'hFFFF, 1'b0, "dec_max");

    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 7));
      case (sel)
        0:       d = 16'h0000;
        1:       d = 16'hFFFF;
        2:       d = 16'h0001;
        3:       d = 16'hFFFE;
        default: d = W'($urandom);
      endcase
      m = 1'($urandom);
      r = ($urandom_range(0, 15) == 0);
      drive(r, d, m, "random");
    end

    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_idu
